skid_stage_register: RTL and testbench
======================================

SKID_STAGE_REGISTER -- requirements
Module: skid_stage_register

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the payload width in bits (WIDTH >= 1).
REQ-002 The block SHALL have parameter RESET_VALUE, default 0, a WIDTH-bit value loaded into every payload register on reset and flush.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low (rst=0 resets).
REQ-005 The block SHALL have port freeze, input, 1 bit: stall; when 1, all state is held and no transfer occurs.
REQ-006 The block SHALL have port flush, input, 1 bit: synchronous discard of all held entries.
REQ-007 The block SHALL have port in_valid, input, 1 bit: the upstream payload is valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block can accept a payload this cycle.
REQ-009 The block SHALL have port in_data, input, WIDTH bits: the upstream payload.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_data holds a valid entry.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts out_data this cycle.
REQ-012 The block SHALL have port out_data, output, WIDTH bits: the oldest held payload.
REQ-013 The block SHALL have port occupancy, output, 2 bits: the number of held entries (0, 1 or 2).

Function
REQ-014 The block SHALL hold two WIDTH-bit registers: main (head) and skid (overflow).
REQ-015 The block SHALL implement states EMPTY (occupancy 0), ONE (main valid, occupancy 1) and TWO (main and skid valid, occupancy 2), with occupancy driven from the registered state.
REQ-016 Accept SHALL be defined as in_valid & in_ready, and emit SHALL be defined as out_valid & out_ready, both sampled at the rising clk edge.
REQ-017 in_ready SHALL equal (state != TWO) & !freeze & !flush & rst.
REQ-018 out_valid SHALL equal (state != EMPTY) & !freeze & !flush & rst.
REQ-019 out_data SHALL always drive the main register, and it SHALL be unchanged while freeze=1.
REQ-020 From EMPTY, accept SHALL load main<=in_data and enter ONE; with no accept, the block SHALL stay in EMPTY.
REQ-021 From ONE, accept with emit SHALL load main<=in_data and stay in ONE.
REQ-022 From ONE, accept without emit SHALL load skid<=in_data and enter TWO.
REQ-023 From ONE, emit without accept SHALL enter EMPTY.
REQ-024 From ONE, neither accept nor emit SHALL hold the state.
REQ-025 From TWO, emit SHALL load main<=skid and enter ONE; with no emit, the block SHALL hold TWO.
REQ-026 In state TWO, accept SHALL be impossible because in_ready=0.
REQ-027 Ordering SHALL be strict FIFO, with no payload lost or duplicated.
REQ-028 Latency SHALL be 1 cycle: a payload accepted at edge N appears on out_data with out_valid=1 after edge N.
REQ-029 Sustained throughput SHALL be 1 payload per cycle when out_ready=1.
REQ-030 flush=1 SHALL take priority over freeze and handshakes: at the next edge the state becomes EMPTY, main and skid become RESET_VALUE, and no transfer is counted that cycle.
REQ-031 freeze=1 with flush=0 SHALL hold the state and both registers exactly, regardless of in_valid and out_ready.
REQ-032 A freeze or flush deassertion SHALL resume operation from the held or emptied state in the same cycle.

Reset
REQ-033 While rst=0, the state SHALL be EMPTY, main and skid SHALL be RESET_VALUE, occupancy SHALL be 0, in_ready SHALL be 0 and out_valid SHALL be 0, asynchronously and independent of clk.
REQ-034 When rst rises, in_ready SHALL be 1 in the same cycle if freeze=0 and flush=0.
REQ-035 Reset asserted mid-operation SHALL discard all held entries immediately, with no partial transfer.

Verification
REQ-036 Streaming: WIDTH=32, out_ready=1, in_data 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 one cycle later each; occupancy stays 1; in_ready stays 1.
REQ-037 Backpressure: out_ready=0, push 0xA then 0xB -> occupancy 2, in_ready=0, out_data=0xA; raise out_ready -> 0xA then 0xB emitted in order; occupancy 1 then 0.
REQ-038 Freeze: state TWO holding 0xA/0xB, freeze=1 for 3 cycles with in_valid=1 and out_ready=1 -> in_ready=0, out_valid=0, out_data=0xA, occupancy 2 held throughout.
REQ-039 Flush: state TWO with freeze=1 and flush=1 for one cycle -> next cycle occupancy 0, out_data=RESET_VALUE, out_valid=0; no transfer during the flush cycle.
REQ-040 Async reset: state ONE holding 0x55, rst=0 between clk edges -> occupancy 0 and out_valid 0 immediately; after rst=1, in_ready=1 and the next accept of 0x66 gives out_data=0x66 one cycle later.
REQ-041 Simultaneous: state ONE holding 0x7, accept 0x8 and emit in the same cycle -> 0x7 consumed, out_data=0x8, occupancy stays 1.

Source files
------------

// File: rtl/skid_stage_register.sv
// Two-entry skid buffer (main + skid) with freeze/flush; 1-cycle latency, full throughput.
// Backpressure: in_ready drops only when both entries are held, so upstream never sees a combinational out_ready path.
module skid_stage_register #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] main_q, main_nxt;
  logic [WIDTH-1:0] skid_q, skid_nxt;
  logic             accept, emit;

  // Gating both handshakes with freeze/flush makes freeze a pure hold in the next-state logic.
  assign in_ready  = (state != TWO)   & ~freeze & ~flush & rst;
  assign out_valid = (state != EMPTY) & ~freeze & ~flush & rst;
  assign out_data  = main_q;
  assign occupancy = state;

  assign accept = in_valid  & in_ready;
  assign emit   = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= EMPTY;
      main_q <= RESET_VALUE;
      skid_q <= RESET_VALUE;
    end else begin
      state  <= state_nxt;
      main_q <= main_nxt;
      skid_q <= skid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    if (flush) begin
      state_nxt = EMPTY;
      main_nxt  = RESET_VALUE;
      skid_nxt  = RESET_VALUE;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_nxt  = in_data;
            state_nxt = ONE;
          end
        end
        ONE: begin
          case ({accept, emit})
            2'b11: main_nxt = in_data;
            2'b10: begin
              skid_nxt  = in_data;
              state_nxt = TWO;
            end
            2'b01: state_nxt = EMPTY;
            default: state_nxt = ONE;
          endcase
        end
        TWO: begin
          if (emit) begin
            main_nxt  = skid_q;
            state_nxt = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_skid_stage_register.sv
// Bench for skid_stage_register: directed vector table, async-reset sequence, random run vs queue model.
module tb_skid_stage_register;

  localparam int          W  = 32;
  localparam logic [W-1:0] RV = 32'hDEAD_BEEF;

  logic         clk = 1'b0;
  logic         rst, freeze, flush, in_valid, out_ready;
  logic [W-1:0] in_data, out_data;
  logic         in_ready, out_valid;
  logic [1:0]   occupancy;

  int n_tests = 0;
  int n_fail  = 0;

  skid_stage_register #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .clk       (clk),
    .rst       (rst),
    .freeze    (freeze),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         fr, fl, iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         e_ir, e_ov;
    logic [W-1:0] e_dat;
    logic [1:0]   e_occ;
  } vec_t;

  function automatic vec_t mk(input logic fr, input logic fl, input logic iv, input logic [W-1:0] d,
                              input logic ordy, input logic e_ir, input logic e_ov,
                              input logic [W-1:0] e_dat, input logic [1:0] e_occ);
    vec_t v;
    v.fr = fr; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_dat = e_dat; v.e_occ = e_occ;
    return v;
  endfunction

  vec_t vecs[18];

  // Reference model: FIFO of held payloads plus the value main keeps once drained.
  logic [W-1:0] q[$];
  logic [W-1:0] stale;

  initial begin
    // Expectations are the outputs seen before the edge that applies the row's inputs.
    //             fr  fl  iv  data    ordy  ir  ov  out_data occ
    vecs[0]  = mk(0,  0,  1,  32'h1,  1,    1,  0,  RV,      0); // streaming
    vecs[1]  = mk(0,  0,  1,  32'h2,  1,    1,  1,  32'h1,   1);
    vecs[2]  = mk(0,  0,  1,  32'h3,  1,    1,  1,  32'h2,   1);
    vecs[3]  = mk(0,  0,  0,  32'h0,  1,    1,  1,  32'h3,   1);
    vecs[4]  = mk(0,  0,  1,  32'hA,  0,    1,  0,  32'h3,   0); // fill to TWO
    vecs[5]  = mk(0,  0,  1,  32'hB,  0,    1,  1,  32'hA,   1);
    vecs[6]  = mk(1,  0,  1,  32'hC,  1,    0,  0,  32'hA,   2); // freeze x3
    vecs[7]  = mk(1,  0,  1,  32'hC,  1,    0,  0,  32'hA,   2);
    vecs[8]  = mk(1,  0,  1,  32'hC,  1,    0,  0,  32'hA,   2);
    vecs[9]  = mk(1,  1,  1,  32'hC,  1,    0,  0,  32'hA,   2); // flush over freeze
    vecs[10] = mk(0,  0,  1,  32'hA,  0,    1,  0,  RV,      0); // backpressure
    vecs[11] = mk(0,  0,  1,  32'hB,  0,    1,  1,  32'hA,   1);
    vecs[12] = mk(0,  0,  1,  32'hC,  0,    0,  1,  32'hA,   2);
    vecs[13] = mk(0,  0,  0,  32'h0,  1,    0,  1,  32'hA,   2);
    vecs[14] = mk(0,  0,  0,  32'h0,  1,    1,  1,  32'hB,   1);
    vecs[15] = mk(0,  0,  1,  32'h7,  0,    1,  0,  32'hB,   0); // simultaneous
    vecs[16] = mk(0,  0,  1,  32'h8,  1,    1,  1,  32'h7,   1);
    vecs[17] = mk(0,  0,  0,  32'h0,  0,    1,  1,  32'h8,   1);

    rst = 1'b0; freeze = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #12;
    check("reset_occ", occupancy, 0);
    check("reset_ir", in_ready, 0);
    check("reset_ov", out_valid, 0);
    check("reset_data", out_data, RV);
    @(negedge clk);
    rst = 1'b1;
    #1 check("rst_rise_ir", in_ready, 1);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      freeze = vecs[i].fr; flush = vecs[i].fl; in_valid = vecs[i].iv;
      in_data = vecs[i].d; out_ready = vecs[i].ordy;
      #1;
      check($sformatf("vec%0d_ir", i), in_ready, vecs[i].e_ir);
      check($sformatf("vec%0d_ov", i), out_valid, vecs[i].e_ov);
      check($sformatf("vec%0d_data", i), out_data, vecs[i].e_dat);
      check($sformatf("vec%0d_occ", i), occupancy, vecs[i].e_occ);
      @(posedge clk);
    end

    // Async reset between edges while holding one entry.
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b1;
    @(posedge clk);
    #2;
    in_valid = 1'b0; out_ready = 1'b0;
    check("pre_rst_data", out_data, 32'h55);
    check("pre_rst_occ", occupancy, 1);
    rst = 1'b0;
    #1;
    check("async_rst_occ", occupancy, 0);
    check("async_rst_ov", out_valid, 0);
    check("async_rst_ir", in_ready, 0);
    check("async_rst_data", out_data, RV);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check("rst_release_ir", in_ready, 1);
    in_valid = 1'b1; in_data = 32'h66;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("post_rst_data", out_data, 32'h66);
    check("post_rst_ov", out_valid, 1);
    check("post_rst_occ", occupancy, 1);

    // Synchronise the model with a flush, then randomised traffic.
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    q.delete();
    stale = RV;
    for (int c = 0; c < 3000; c++) begin
      logic e_ir, e_ov, acc, em;
      logic [W-1:0] e_dat;
      @(negedge clk);
      freeze    = ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = $urandom;
      #1;
      e_ir  = (q.size() < 2) && !freeze && !flush;
      e_ov  = (q.size() > 0) && !freeze && !flush;
      e_dat = (q.size() > 0) ? q[0] : stale;
      check("rand_ir", in_ready, e_ir);
      check("rand_ov", out_valid, e_ov);
      check("rand_data", out_data, e_dat);
      check("rand_occ", occupancy, q.size());
      acc = in_valid && e_ir;
      em  = e_ov && out_ready;
      @(posedge clk);
      if (flush) begin
        q.delete();
        stale = RV;
      end else begin
        if (em) stale = q.pop_front();
        if (acc) q.push_back(in_data);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
